// File: rtl/iob_pbus_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave port among N_MASTERS masters, with read-response routing.
// Optional build macro: IOB_PBUS_ARB_FIXED_PRIO_EN (lowest eligible index always wins).

module iob_pbus_rr_arbiter_chk (
  input logic clk_i,
  input logic arst_i,
  input logic cke_i,
  input logic s_rvalid_i,
  input logic fifo_empty_i
);
  // A response with no outstanding read is a slave protocol error.
  always @(posedge clk_i) begin
    if (!arst_i && cke_i && s_rvalid_i) begin
      assert (!fifo_empty_i) else $error("s_rvalid_i with no outstanding read");
    end
  end
endmodule

module iob_pbus_rr_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_MASTERS = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_i,
  input  logic [N_MASTERS-1:0]          m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic                          s_ready_i,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i
);

  localparam int ID_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(MAX_OUTST);
  localparam int CNT_W  = PTR_W + 1;

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 locked_q, locked_d;
  logic [ID_W-1:0]      fifo_q [MAX_OUTST];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic [ID_W-1:0]      grant_s;
  logic                 found_s;
  logic [N_MASTERS-1:0] is_write_s;
  logic [N_MASTERS-1:0] eligible_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  int                   idx_s;

  assign fifo_full_s  = (count_q == CNT_W'(MAX_OUTST));
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});

  // Reads need a free tracking slot; writes are always eligible.
  always_comb begin
    is_write_s = {N_MASTERS{1'b0}};
    eligible_s = {N_MASTERS{1'b0}};
    for (int k = 0; k < N_MASTERS; k++) begin
      is_write_s[k] = |m_wstrb_i[k*STRB_W +: STRB_W];
      eligible_s[k] = m_avalid_i[k] && (is_write_s[k] || !fifo_full_s);
    end
  end

  // Grant select: held grant while locked, else first eligible index from rr_ptr upward.
  always_comb begin
    grant_s = {ID_W{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    if (locked_q) begin
      grant_s = grant_q;
      found_s = m_avalid_i[grant_q];
    end else begin
      // Descending scan so the smallest offset from rr_ptr is written last and wins.
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        idx_s   = (int'(rr_ptr_q) + i) % N_MASTERS;
        grant_s = eligible_s[idx_s] ? ID_W'(idx_s) : grant_s;
        found_s = found_s | eligible_s[idx_s];
      end
    end
  end

  assign s_avalid_o = found_s & ~arst_i;
  assign s_addr_o   = m_addr_i[grant_s*ADDR_W +: ADDR_W];
  assign s_wdata_o  = m_wdata_i[grant_s*DATA_W +: DATA_W];
  assign s_wstrb_o  = m_wstrb_i[grant_s*STRB_W +: STRB_W];
  assign accept_s   = s_avalid_o & s_ready_i;
  assign push_s     = accept_s & ~is_write_s[grant_s];
  assign pop_s      = s_rvalid_i & ~fifo_empty_s;
  assign m_rdata_o  = {N_MASTERS{s_rdata_i}};

  // One-hot handshake and response routing back to the masters.
  always_comb begin
    m_ready_o  = {N_MASTERS{1'b0}};
    m_rvalid_o = {N_MASTERS{1'b0}};
    for (int k = 0; k < N_MASTERS; k++) begin
      m_ready_o[k]  = accept_s && (grant_s == ID_W'(k));
      m_rvalid_o[k] = pop_s && (fifo_q[rd_ptr_q] == ID_W'(k));
    end
  end

  // Next-state for arbitration pointer and lock.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    if (accept_s) begin
      locked_d = 1'b0;
`ifdef IOB_PBUS_ARB_FIXED_PRIO_EN
      rr_ptr_d = {ID_W{1'b0}};
`else
      rr_ptr_d = (grant_s == ID_W'(N_MASTERS - 1)) ? {ID_W{1'b0}} : grant_s + 1'b1;
`endif
    end else if (s_avalid_o) begin
      locked_d = 1'b1;
      grant_d  = grant_s;
    end else begin
      locked_d = 1'b0;
    end
  end

  // State registers, frozen while cke_i is low.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rr_ptr_q <= {ID_W{1'b0}};
      grant_q  <= {ID_W{1'b0}};
      locked_q <= 1'b0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int j = 0; j < MAX_OUTST; j++) begin
        fifo_q[j] <= {ID_W{1'b0}};
      end
    end else if (cke_i) begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= grant_s;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end else begin
      rr_ptr_q <= rr_ptr_q;
      grant_q  <= grant_q;
      locked_q <= locked_q;
      wr_ptr_q <= wr_ptr_q;
      rd_ptr_q <= rd_ptr_q;
      count_q  <= count_q;
    end
  end

`ifndef SYNTHESIS
  iob_pbus_rr_arbiter_chk u_chk (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .cke_i       (cke_i),
    .s_rvalid_i  (s_rvalid_i),
    .fifo_empty_i(fifo_empty_s)
  );
`endif

endmodule

// File: tb/tb_iob_pbus_rr_arbiter.sv
// Directed bench for iob_pbus_rr_arbiter with N_MASTERS=2, MAX_OUTST=4.
// Build with IOB_PBUS_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant instead.
`timescale 1ns/1ps
module tb_iob_pbus_rr_arbiter;
  logic        clk_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        arst_i = 1'b1;
  logic [1:0]  m_avalid_i = 2'b00;
  logic [63:0] m_addr_i = 64'h0;
  logic [63:0] m_wdata_i = 64'h0;
  logic [7:0]  m_wstrb_i = 8'h0;
  logic [1:0]  m_ready_o;
  logic [1:0]  m_rvalid_o;
  logic [63:0] m_rdata_o;
  logic        s_avalid_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic        s_ready_i = 1'b0;
  logic        s_rvalid_i = 1'b0;
  logic [31:0] s_rdata_i = 32'h0;

  int tests = 0;
  int fails = 0;

  iob_pbus_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .N_MASTERS(2), .MAX_OUTST(4)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [31:0] a, input logic wr);
    m_avalid_i[k]        = v;
    m_addr_i[k*32 +: 32] = a;
    m_wdata_i[k*32 +: 32] = a ^ 32'hA5A5_A5A5;
    m_wstrb_i[k*4 +: 4]  = wr ? 4'hF : 4'h0;
  endtask

  task automatic test_reset();
    arst_i = 1'b1; s_ready_i = 1'b1; s_rvalid_i = 1'b1;
    drive(0, 1'b1, 32'h100, 1'b1);
    drive(1, 1'b1, 32'h200, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    tests++; if (s_avalid_o !== 1'b0) begin fails++; $display("FAIL reset_s_avalid got %0b exp 0", s_avalid_o); end
    tests++; if (m_ready_o !== 2'b00) begin fails++; $display("FAIL reset_m_ready got %b exp 00", m_ready_o); end
    tests++; if (m_rvalid_o !== 2'b00) begin fails++; $display("FAIL reset_m_rvalid got %b exp 00", m_rvalid_o); end
    s_rvalid_i = 1'b0; s_ready_i = 1'b0; arst_i = 1'b0;
    #1;
    tests++; if ({s_avalid_o, s_addr_o} !== {1'b1, 32'h100}) begin
      fails++; $display("FAIL release_grant0 got v=%0b addr=%h exp v=1 addr=00000100", s_avalid_o, s_addr_o); end
    tests++; if ({s_wstrb_o, s_wdata_o} !== {4'hF, 32'h100 ^ 32'hA5A5_A5A5}) begin
      fails++; $display("FAIL release_wfields got strb=%h data=%h", s_wstrb_o, s_wdata_o); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_addr;
    s_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #1;
      exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
      tests++; if ({m_ready_o, s_addr_o} !== {exp_rdy, exp_addr}) begin
        fails++; $display("FAIL contention_%0d got rdy=%b addr=%h exp rdy=%b addr=%h", i, m_ready_o, s_addr_o, exp_rdy, exp_addr); end
    end
    cyc();
  endtask

  task automatic test_lock();
    drive(1, 1'b1, 32'h10, 1'b0);
    drive(0, 1'b1, 32'h20, 1'b1);
    s_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if ({s_avalid_o, s_addr_o, s_wstrb_o, m_ready_o} !== {1'b1, 32'h10, 4'h0, 2'b00}) begin
        fails++; $display("FAIL lock_hold_%0d got v=%0b addr=%h strb=%h rdy=%b exp v=1 addr=00000010 strb=0 rdy=00", c, s_avalid_o, s_addr_o, s_wstrb_o, m_ready_o); end
      cyc();
    end
    s_ready_i = 1'b1;
    #1;
    tests++; if ({m_ready_o, s_addr_o} !== {2'b10, 32'h10}) begin
      fails++; $display("FAIL lock_accept got rdy=%b addr=%h exp rdy=10 addr=00000010", m_ready_o, s_addr_o); end
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    tests++; if ({m_ready_o, s_addr_o} !== {2'b01, 32'h20}) begin
      fails++; $display("FAIL lock_next_m0 got rdy=%b addr=%h exp rdy=01 addr=00000020", m_ready_o, s_addr_o); end
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0);
    s_ready_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_0001;
    #1;
    tests++; if ({m_rvalid_o, m_rdata_o[32 +: 32]} !== {2'b10, 32'hDEAD_0001}) begin
      fails++; $display("FAIL lock_read_resp got rv=%b data=%h exp rv=10 data=dead0001", m_rvalid_o, m_rdata_o[32 +: 32]); end
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    tests++; if ({m_rvalid_o, s_avalid_o} !== 3'b000) begin
      fails++; $display("FAIL lock_idle got rv=%b v=%0b exp rv=00 v=0", m_rvalid_o, s_avalid_o); end
  endtask

  task automatic issue_read(input int m, input logic [31:0] a, input string tag);
    logic [1:0] exp_rdy;
    exp_rdy = (m == 0) ? 2'b01 : 2'b10;
    drive(m, 1'b1, a, 1'b0);
    s_ready_i = 1'b1;
    #1;
    tests++; if ({m_ready_o, s_addr_o} !== {exp_rdy, a}) begin
      fails++; $display("FAIL %s_m%0d got rdy=%b addr=%h exp rdy=%b addr=%h", tag, m, m_ready_o, s_addr_o, exp_rdy, a); end
    cyc();
    drive(m, 1'b0, 32'h0, 1'b0);
    s_ready_i = 1'b0;
  endtask

  task automatic test_routing();
    logic [31:0] data [3];
    logic [1:0]  exp_rv [3];
    data   = '{32'hAAAA_0000, 32'hBBBB_1111, 32'hCCCC_2222};
    exp_rv = '{2'b01, 2'b10, 2'b01};
    issue_read(0, 32'h300, "route_req");
    issue_read(1, 32'h304, "route_req");
    issue_read(0, 32'h308, "route_req");
    for (int i = 0; i < 3; i++) begin
      s_rvalid_i = 1'b1; s_rdata_i = data[i];
      #1;
      tests++; if ({m_rvalid_o, m_rdata_o} !== {exp_rv[i], data[i], data[i]}) begin
        fails++; $display("FAIL route_resp_%0d got rv=%b data=%h exp rv=%b data=%h", i, m_rvalid_o, m_rdata_o, exp_rv[i], data[i]); end
      cyc();
    end
    s_rvalid_i = 1'b0;
  endtask

  task automatic test_full();
    logic [1:0] exp_rv [4];
    exp_rv = '{2'b10, 2'b01, 2'b10, 2'b01};
    issue_read(0, 32'h400, "full_fill");
    issue_read(1, 32'h404, "full_fill");
    issue_read(0, 32'h408, "full_fill");
    issue_read(1, 32'h40C, "full_fill");
    drive(0, 1'b1, 32'h410, 1'b0);
    drive(1, 1'b1, 32'h500, 1'b1);
    s_ready_i = 1'b1;
    #1;
    tests++; if ({m_ready_o, s_addr_o} !== {2'b10, 32'h500}) begin
      fails++; $display("FAIL full_write_passes got rdy=%b addr=%h exp rdy=10 addr=00000500", m_ready_o, s_addr_o); end
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    tests++; if ({m_ready_o, s_avalid_o} !== 3'b000) begin
      fails++; $display("FAIL full_read_blocked got rdy=%b v=%0b exp rdy=00 v=0", m_ready_o, s_avalid_o); end
    cyc();
    s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
    #1;
    tests++; if ({m_rvalid_o, m_ready_o} !== 4'b0100) begin
      fails++; $display("FAIL full_pop got rv=%b rdy=%b exp rv=01 rdy=00", m_rvalid_o, m_ready_o); end
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    tests++; if ({m_ready_o, s_addr_o} !== {2'b01, 32'h410}) begin
      fails++; $display("FAIL full_5th_accept got rdy=%b addr=%h exp rdy=01 addr=00000410", m_ready_o, s_addr_o); end
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0);
    s_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid_i = 1'b1; s_rdata_i = 32'h9000_0000 + i;
      #1;
      tests++; if (m_rvalid_o !== exp_rv[i]) begin
        fails++; $display("FAIL full_drain_%0d got rv=%b exp rv=%b", i, m_rvalid_o, exp_rv[i]); end
      cyc();
    end
    s_rvalid_i = 1'b0;
    #1;
    tests++; if ({m_rvalid_o, s_avalid_o} !== 3'b000) begin
      fails++; $display("FAIL full_end_idle got rv=%b v=%0b exp rv=00 v=0", m_rvalid_o, s_avalid_o); end
  endtask

  task automatic test_fixed_prio();
    s_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      tests++; if ({m_ready_o, s_addr_o} !== {2'b01, 32'h100}) begin
        fails++; $display("FAIL fixed_m0_%0d got rdy=%b addr=%h exp rdy=01 addr=00000100", i, m_ready_o, s_addr_o); end
    end
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    tests++; if ({m_ready_o, s_addr_o} !== {2'b10, 32'h200}) begin
      fails++; $display("FAIL fixed_m1 got rdy=%b addr=%h exp rdy=10 addr=00000200", m_ready_o, s_addr_o); end
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0);
    s_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef IOB_PBUS_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
    test_lock();
    test_routing();
    test_full();
`endif
    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
